exe_stage_unit: RTL and testbench
=================================

// Module: exe_stage_unit
// PURPOSE
//  Execute stage of the 5-stage ARM pipeline, fed by the ID/EX register.
//  Generates Val2 (immediate rotate or shifted Rm), runs the ALU, and holds the NZCV status register.
//  Resolves branch target/taken and registers results into the EX/MEM boundary for the MEM stage.
//  Outputs map one-to-one onto MEM inputs: ALU_result, Val_Rm, Dest, WB_EN, MEM_R_EN, MEM_W_EN.
// PARAMETERS
//  DW     32  datapath width; only 32 is supported
//  RW      4  register index width (Dest)
// PORTS
//  clk            in   1   pipeline clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  freeze         in   1   hold EX/MEM register and SR (memory stall)
//  flush          in   1   load bubble into EX/MEM register
//  EXE_CMD        in   4   ALU op
//  WB_EN_IN       in   1   write-back enable from ID/EX
//  MEM_R_EN_IN    in   1   load enable from ID/EX
//  MEM_W_EN_IN    in   1   store enable from ID/EX
//  S              in   1   update SR
//  B              in   1   branch instruction
//  imm            in   1   Val2 from immediate
//  Shift_operand  in  12   operand2 field
//  Signed_imm_24  in  24   branch offset
//  PC_IN          in  32   PC+4 of this instruction
//  Val_Rn         in  32   register-file Rn
//  Val_Rm_IN      in  32   register-file Rm
//  Dest_IN        in   4   destination register
//  sel_src1       in   2   forwarding select, Rn (FORWARDING_EN only)
//  sel_src2       in   2   forwarding select, Rm (FORWARDING_EN only)
//  MEM_fwd_val    in  32   ALU_result in MEM stage (FORWARDING_EN only)
//  WB_fwd_val     in  32   value being written back (FORWARDING_EN only)
//  SR             out  4   {N,Z,C,V} to ID condition check
//  Branch_taken   out  1   combinational; equals B
//  Branch_addr    out 32   combinational; PC_IN + sext(Signed_imm_24)<<2
//  WB_EN, MEM_R_EN, MEM_W_EN  out 1   registered controls
//  ALU_result     out 32   registered ALU result (address for LDR/STR)
//  Val_Rm         out 32   registered store data (post-forwarding)
//  Dest           out  4   registered destination
// BEHAVIOUR
//  Reset (rst=0, async): SR=0, every registered output=0; Branch_* stay combinational.
//  Latency: one cycle. Inputs at edge k appear on the registered outputs after edge k.
//  Priority at each edge: freeze > flush > load. freeze=1 holds registers and SR.
//  flush=1: WB_EN, MEM_R_EN, MEM_W_EN <= 0; data fields don't-care (loaded); SR not updated.
//  Val2:
//   - imm=1: {24'b0,SO[7:0]} rotated right by 2*SO[11:8].
//   - else if MEM_R_EN_IN|MEM_W_EN_IN: {20'b0,SO[11:0]}.
//   - else Rm shifted by SO[11:7], type SO[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
//   - A shift of 0 passes Rm through.
//  EXE_CMD:
//   - 0001 MOV=Val2; 1001 MVN=~Val2; 0010 ADD (also LDR/STR); 0011 ADC=Rn+Val2+C.
//   - 0100 SUB/CMP=Rn-Val2; 0101 SBC=Rn-Val2-!C.
//   - 0110 AND/TST; 0111 ORR; 1000 EOR.
//   - Any other code: result 0, flags N/Z from 0.
//  Flags:
//   - N=res[31]; Z=(res==0).
//   - Arithmetic: C=carry out (SUB/SBC: C=no borrow); V=signed overflow.
//   - Logical/MOV/MVN: C and V keep their old SR value.
//   - SR <= flags at the edge when S=1, freeze=0 and flush=0.
//   - SR reads in ID see the pre-update value (no bypass).
//  CMP/TST arrive with WB_EN_IN=0 from ID; this block does not gate them.
//  Branch_addr wraps modulo 2^32; the negative offset is sign-extended before the shift.
//  Reset asserted mid-stall clears everything; the pipeline restarts from a bubble.
// CONFIGURATION
//  FORWARDING_EN defined: operand muxes are built.
//   - Rn = sel_src1 {00 Val_Rn, 01 MEM_fwd_val, 10 WB_fwd_val, 11 Val_Rn}.
//   - Rm uses sel_src2 the same way; the forwarded Rm feeds both the shifter and the Val_Rm output.
//  FORWARDING_EN undefined: Rn=Val_Rn, Rm=Val_Rm_IN. Forwarding ports exist but are ignored; the hazard unit must stall.
// TESTING
//  1 Reset: rst=0 mid-run -> all outputs 0 and SR=0 immediately; after release, a bubble is visible.
//  2 ADDS, Rn=0x7FFFFFFF, imm=1, SO=0x001: ALU_result=0x80000000, SR=1001 (N,V).
//  3 SUBS, Rn=5, Rm=5, SO=0: result=0, SR=0110 (Z,C); then SBC 5-3 with C=1 -> 2.
//  4 Val2:
//    a imm SO=0x4FF -> 0xFF000000;
//    b Rm=0x80000001, ASR#1 (SO=0x0C0) -> 0xC0000000; ROR#1 -> 0xC0000000.
//  5 freeze held 3 cycles while inputs change: outputs and SR constant.
//    Then freeze+flush together: freeze wins. Next flush alone: controls=0.
//  6 B=1, PC_IN=0x100, imm24=0xFFFFFE -> Branch_addr=0xF8.
//    FORWARDING_EN, sel_src2=01, MEM_fwd_val=0xAA -> Val_Rm=0xAA.

Source files
------------

// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 generation, ALU with NZCV status register, branch target, EX/MEM register.
// Optional macro FORWARDING_EN builds the Rn/Rm forwarding muxes driven by sel_src1/sel_src2.
module exe_stage_unit #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic [3:0]    EXE_CMD,
    input  logic          WB_EN_IN,
    input  logic          MEM_R_EN_IN,
    input  logic          MEM_W_EN_IN,
    input  logic          S,
    input  logic          B,
    input  logic          imm,
    input  logic [11:0]   Shift_operand,
    input  logic [23:0]   Signed_imm_24,
    input  logic [DW-1:0] PC_IN,
    input  logic [DW-1:0] Val_Rn,
    input  logic [DW-1:0] Val_Rm_IN,
    input  logic [RW-1:0] Dest_IN,
    input  logic [1:0]    sel_src1,
    input  logic [1:0]    sel_src2,
    input  logic [DW-1:0] MEM_fwd_val,
    input  logic [DW-1:0] WB_fwd_val,
    output logic [3:0]    SR,
    output logic          Branch_taken,
    output logic [DW-1:0] Branch_addr,
    output logic          WB_EN,
    output logic          MEM_R_EN,
    output logic          MEM_W_EN,
    output logic [DW-1:0] ALU_result,
    output logic [DW-1:0] Val_Rm,
    output logic [RW-1:0] Dest
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    function automatic logic [DW-1:0] ror_f(input logic [DW-1:0] x, input logic [4:0] n);
        logic [2*DW-1:0] t;
        t = {x, x} >> n;
        return t[DW-1:0];
    endfunction

    logic [DW-1:0] rn_s, rm_s, val2_s, res_s;
    logic [DW:0]   sum_s;
    logic          c_s, v_s;
    logic [3:0]    sr_d, sr_q;
    logic          wb_en_d, wb_en_q, mem_r_en_d, mem_r_en_q, mem_w_en_d, mem_w_en_q;
    logic [DW-1:0] alu_result_d, alu_result_q, val_rm_d, val_rm_q;
    logic [RW-1:0] dest_d, dest_q;

    // Operand selection (forwarding muxes when enabled)
    always_comb begin
`ifdef FORWARDING_EN
        case (sel_src1)
            2'b01:   rn_s = MEM_fwd_val;
            2'b10:   rn_s = WB_fwd_val;
            default: rn_s = Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   rm_s = MEM_fwd_val;
            2'b10:   rm_s = WB_fwd_val;
            default: rm_s = Val_Rm_IN;
        endcase
`else
        rn_s = Val_Rn;
        rm_s = Val_Rm_IN;
`endif
    end

`ifndef FORWARDING_EN
    logic unused_fwd_s;
    assign unused_fwd_s = ^{sel_src1, sel_src2, MEM_fwd_val, WB_fwd_val};
`endif

    // Val2 generation: rotated immediate, memory offset, or shifted Rm
    always_comb begin
        val2_s = rm_s;
        if (imm) begin
            val2_s = ror_f({24'd0, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0});
        end else if (MEM_R_EN_IN || MEM_W_EN_IN) begin
            val2_s = {20'd0, Shift_operand};
        end else begin
            case (Shift_operand[6:5])
                2'b00:   val2_s = rm_s << Shift_operand[11:7];
                2'b01:   val2_s = rm_s >> Shift_operand[11:7];
                2'b10:   val2_s = $signed(rm_s) >>> Shift_operand[11:7];
                2'b11:   val2_s = ror_f(rm_s, Shift_operand[11:7]);
                default: val2_s = rm_s;
            endcase
        end
    end

    // ALU; subtraction is Rn + ~Val2 + carry-in so C reads as "no borrow"
    always_comb begin
        sum_s = {(DW+1){1'b0}};
        res_s = {DW{1'b0}};
        c_s   = sr_q[1];
        v_s   = sr_q[0];
        case (EXE_CMD)
            CMD_MOV: res_s = val2_s;
            CMD_MVN: res_s = ~val2_s;
            CMD_ADD, CMD_ADC: begin
                sum_s = {1'b0, rn_s} + {1'b0, val2_s}
                      + {{DW{1'b0}}, (EXE_CMD == CMD_ADC) ? sr_q[1] : 1'b0};
                res_s = sum_s[DW-1:0];
                c_s   = sum_s[DW];
                v_s   = (rn_s[DW-1] == val2_s[DW-1]) && (res_s[DW-1] != rn_s[DW-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum_s = {1'b0, rn_s} + {1'b0, ~val2_s}
                      + {{DW{1'b0}}, (EXE_CMD == CMD_SBC) ? sr_q[1] : 1'b1};
                res_s = sum_s[DW-1:0];
                c_s   = sum_s[DW];
                v_s   = (rn_s[DW-1] != val2_s[DW-1]) && (res_s[DW-1] != rn_s[DW-1]);
            end
            CMD_AND: res_s = rn_s & val2_s;
            CMD_ORR: res_s = rn_s | val2_s;
            CMD_EOR: res_s = rn_s ^ val2_s;
            default: res_s = {DW{1'b0}};
        endcase
    end

    // Next state of EX/MEM register and SR: freeze > flush > load
    always_comb begin
        sr_d         = sr_q;
        wb_en_d      = wb_en_q;
        mem_r_en_d   = mem_r_en_q;
        mem_w_en_d   = mem_w_en_q;
        alu_result_d = alu_result_q;
        val_rm_d     = val_rm_q;
        dest_d       = dest_q;
        if (freeze) begin
            sr_d = sr_q;
        end else begin
            alu_result_d = res_s;
            val_rm_d     = rm_s;
            dest_d       = Dest_IN;
            if (flush) begin
                wb_en_d    = 1'b0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
            end else begin
                wb_en_d    = WB_EN_IN;
                mem_r_en_d = MEM_R_EN_IN;
                mem_w_en_d = MEM_W_EN_IN;
                if (S) begin
                    sr_d = {res_s[DW-1], (res_s == {DW{1'b0}}), c_s, v_s};
                end else begin
                    sr_d = sr_q;
                end
            end
        end
    end

    // EX/MEM pipeline register and status register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q         <= 4'd0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            alu_result_q <= {DW{1'b0}};
            val_rm_q     <= {DW{1'b0}};
            dest_q       <= {RW{1'b0}};
        end else begin
            sr_q         <= sr_d;
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            alu_result_q <= alu_result_d;
            val_rm_q     <= val_rm_d;
            dest_q       <= dest_d;
        end
    end

    assign SR           = sr_q;
    assign WB_EN        = wb_en_q;
    assign MEM_R_EN     = mem_r_en_q;
    assign MEM_W_EN     = mem_w_en_q;
    assign ALU_result   = alu_result_q;
    assign Val_Rm       = val_rm_q;
    assign Dest         = dest_q;
    assign Branch_taken = B;
    assign Branch_addr  = PC_IN + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed self-checking bench for exe_stage_unit; expected values are hand-computed.
module tb_exe_stage_unit;

    logic        clk, rst, freeze, flush;
    logic [3:0]  EXE_CMD;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, S, B, imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [31:0] PC_IN, Val_Rn, Val_Rm_IN, MEM_fwd_val, WB_fwd_val;
    logic [3:0]  Dest_IN;
    logic [1:0]  sel_src1, sel_src2;
    logic [3:0]  SR;
    logic        Branch_taken, WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] Branch_addr, ALU_result, Val_Rm;
    logic [3:0]  Dest;

    int n_pass  = 0;
    int n_total = 0;

    exe_stage_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .EXE_CMD(EXE_CMD),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .S(S), .B(B), .imm(imm), .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
        .PC_IN(PC_IN), .Val_Rn(Val_Rn), .Val_Rm_IN(Val_Rm_IN), .Dest_IN(Dest_IN),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .MEM_fwd_val(MEM_fwd_val), .WB_fwd_val(WB_fwd_val),
        .SR(SR), .Branch_taken(Branch_taken), .Branch_addr(Branch_addr),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_result(ALU_result), .Val_Rm(Val_Rm), .Dest(Dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] cmd, input logic s_i, input logic imm_i,
                      input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
        EXE_CMD = cmd; S = s_i; imm = imm_i; Shift_operand = so; Val_Rn = rn; Val_Rm_IN = rm;
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; EXE_CMD = 4'd0;
        WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0; S = 1'b0; B = 1'b0; imm = 1'b0;
        Shift_operand = 12'd0; Signed_imm_24 = 24'd0; PC_IN = 32'd0; Val_Rn = 32'd0;
        Val_Rm_IN = 32'd0; Dest_IN = 4'd0; sel_src1 = 2'b00; sel_src2 = 2'b00;
        MEM_fwd_val = 32'd0; WB_fwd_val = 32'd0;
        step(); step();
        chk("reset_alu", ALU_result, 32'd0);
        chk("reset_sr", {28'd0, SR}, 32'd0);
        chk("reset_ctl", {29'd0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
        rst = 1'b1;

        // ADDS 0x7FFFFFFF + 1 -> N,V
        WB_EN_IN = 1'b1; Dest_IN = 4'd3;
        op(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0000_1234);
        step();
        chk("adds_res", ALU_result, 32'h8000_0000);
        chk("adds_sr", {28'd0, SR}, 32'h9);
        chk("adds_wb", {31'd0, WB_EN}, 32'd1);
        chk("adds_dest", {28'd0, Dest}, 32'd3);
        chk("adds_valrm", Val_Rm, 32'h0000_1234);

        op(4'b0100, 1'b1, 1'b0, 12'h000, 32'd5, 32'd5);
        step();
        chk("subs_res", ALU_result, 32'd0);
        chk("subs_sr", {28'd0, SR}, 32'h6);

        op(4'b0101, 1'b1, 1'b0, 12'h000, 32'd5, 32'd3);
        step();
        chk("sbcs_res", ALU_result, 32'd2);
        chk("sbcs_sr", {28'd0, SR}, 32'h2);

        op(4'b0011, 1'b1, 1'b1, 12'h000, 32'hFFFF_FFFF, 32'd0);
        step();
        chk("adcs_res", ALU_result, 32'd0);
        chk("adcs_sr", {28'd0, SR}, 32'h6);

        // Logical MOVS keeps C and V
        op(4'b0001, 1'b1, 1'b1, 12'h4FF, 32'd0, 32'd0);
        step();
        chk("mov_imm_rot", ALU_result, 32'hFF00_0000);
        chk("movs_sr", {28'd0, SR}, 32'hA);

        op(4'b1001, 1'b0, 1'b1, 12'h000, 32'd0, 32'd0);
        step();
        chk("mvn", ALU_result, 32'hFFFF_FFFF);
        chk("mvn_sr_hold", {28'd0, SR}, 32'hA);

        op(4'b0001, 1'b0, 1'b0, 12'h0C0, 32'd0, 32'h8000_0001);
        step();
        chk("asr1", ALU_result, 32'hC000_0000);
        op(4'b0001, 1'b0, 1'b0, 12'h0E0, 32'd0, 32'h8000_0001);
        step();
        chk("ror1", ALU_result, 32'hC000_0000);
        op(4'b0001, 1'b0, 1'b0, 12'h200, 32'd0, 32'h8000_0001);
        step();
        chk("lsl4", ALU_result, 32'h0000_0010);
        op(4'b0001, 1'b0, 1'b0, 12'h220, 32'd0, 32'h8000_0001);
        step();
        chk("lsr4", ALU_result, 32'h0800_0000);
        op(4'b0001, 1'b0, 1'b0, 12'h040, 32'd0, 32'h8000_0001);
        step();
        chk("asr0_pass", ALU_result, 32'h8000_0001);

        op(4'b1111, 1'b1, 1'b0, 12'h000, 32'd7, 32'd9);
        step();
        chk("undef_res", ALU_result, 32'd0);
        chk("undef_sr", {28'd0, SR}, 32'h6);

        op(4'b0110, 1'b0, 1'b1, 12'h0FF, 32'h0000_F0F0, 32'd0);
        step();
        chk("and", ALU_result, 32'h0000_00F0);
        op(4'b0111, 1'b0, 1'b1, 12'h0FF, 32'h0000_F0F0, 32'd0);
        step();
        chk("orr", ALU_result, 32'h0000_F0FF);
        op(4'b1000, 1'b0, 1'b1, 12'h0FF, 32'h0000_F0F0, 32'd0);
        step();
        chk("eor", ALU_result, 32'h0000_F00F);

        // LDR address: 12-bit offset zero-extended
        MEM_R_EN_IN = 1'b1;
        op(4'b0010, 1'b0, 1'b0, 12'hFFF, 32'h0000_1000, 32'd0);
        step();
        chk("ldr_addr", ALU_result, 32'h0000_1FFF);
        chk("ldr_ren", {31'd0, MEM_R_EN}, 32'd1);

        // Freeze for 3 cycles with changing inputs
        freeze = 1'b1; MEM_R_EN_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op(4'b0010, 1'b1, 1'b1, 12'h001, 32'(i + 40), 32'(i));
            step();
            chk("frz_alu", ALU_result, 32'h0000_1FFF);
            chk("frz_sr", {28'd0, SR}, 32'h6);
            chk("frz_ren", {31'd0, MEM_R_EN}, 32'd1);
        end
        flush = 1'b1;
        step();
        chk("frzflush_alu", ALU_result, 32'h0000_1FFF);
        chk("frzflush_ren", {31'd0, MEM_R_EN}, 32'd1);
        freeze = 1'b0;
        step();
        chk("flush_ctl", {29'd0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
        chk("flush_sr", {28'd0, SR}, 32'h6);
        flush = 1'b0;

        // Reset during a stall
        MEM_W_EN_IN = 1'b1; Dest_IN = 4'd7;
        op(4'b0010, 1'b0, 1'b0, 12'h004, 32'h0000_0200, 32'h0000_DEAD);
        step();
        chk("str_addr", ALU_result, 32'h0000_0204);
        chk("str_data", Val_Rm, 32'h0000_DEAD);
        chk("str_wen", {31'd0, MEM_W_EN}, 32'd1);
        freeze = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_alu", ALU_result, 32'd0);
        chk("rst_mid_sr", {28'd0, SR}, 32'd0);
        chk("rst_mid_misc", {Val_Rm[27:0], Dest}, 32'd0);
        chk("rst_mid_ctl", {29'd0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
        step();
        rst = 1'b1; freeze = 1'b0;
        #1;
        chk("bubble_ctl", {29'd0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
        step();
        chk("restart_wen", {31'd0, MEM_W_EN}, 32'd1);
        MEM_W_EN_IN = 1'b0;

        // Branch target is combinational
        B = 1'b1; PC_IN = 32'h0000_0100; Signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("br_taken", {31'd0, Branch_taken}, 32'd1);
        chk("br_neg", Branch_addr, 32'h0000_00F8);
        Signed_imm_24 = 24'h000010;
        #1;
        chk("br_pos", Branch_addr, 32'h0000_0140);
        PC_IN = 32'hFFFF_FFFC; Signed_imm_24 = 24'h000001;
        #1;
        chk("br_wrap", Branch_addr, 32'h0000_0000);
        B = 1'b0;
        #1;
        chk("br_not", {31'd0, Branch_taken}, 32'd0);

        // Rm forwarding
        sel_src2 = 2'b01; MEM_fwd_val = 32'h0000_00AA;
        op(4'b0001, 1'b0, 1'b0, 12'h000, 32'd0, 32'h0000_0055);
        step();
`ifdef FORWARDING_EN
        chk("fwd_valrm", Val_Rm, 32'h0000_00AA);
        chk("fwd_alu", ALU_result, 32'h0000_00AA);
`else
        chk("nofwd_valrm", Val_Rm, 32'h0000_0055);
        chk("nofwd_alu", ALU_result, 32'h0000_0055);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
